// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception unit: SR/Cause/EPC/PRId storage, mfc0/mtc0/eret
// service, and same-cycle exception/interrupt request generation at M stage.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VAL   = 32'h4255_4141,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cp0_raddr,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_we,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exccode,
  input  logic        exl_clr,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] REG_SR    = AW'(12);
  localparam logic [AW-1:0] REG_CAUSE = AW'(13);
  localparam logic [AW-1:0] REG_EPC   = AW'(14);
  localparam logic [AW-1:0] REG_PRID  = AW'(15);

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] epc_raw;

  // Request decode; reset suppresses any request
  always_comb begin
    int_req = ~reset & (|(hw_int & im_q)) & ie_q & ~exl_q;
    exc_req = ~reset & (m_exccode != 5'd0) & ~exl_q;
    req     = int_req | exc_req;
  end

  // Architectural register images as seen by mfc0
  always_comb begin
    sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_val = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
  end

  // mfc0 read mux, pre-edge values only
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      REG_SR:    cp0_rdata = sr_val;
      REG_CAUSE: cp0_rdata = cause_val;
      REG_EPC:   cp0_rdata = epc_q;
      REG_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = 32'd0;
    endcase
  end

  // Next-state: exception entry takes precedence over mtc0/eret
  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = hw_int;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    epc_raw   = m_bd ? (m_pc - 32'd4) : m_pc;

    if (req) begin
      exl_d     = 1'b1;
      exccode_d = int_req ? 5'd0 : m_exccode;
      bd_d      = m_bd;
      epc_d     = {epc_raw[31:2], 2'b00};
    end else begin
      if (cp0_we && (cp0_waddr == REG_SR)) begin
        im_d  = cp0_wdata[15:10];
        exl_d = cp0_wdata[1];
        ie_d  = cp0_wdata[0];
      end
      if (cp0_we && (cp0_waddr == REG_EPC)) begin
        epc_d = {cp0_wdata[31:2], 2'b00};
      end
      // eret clear is applied after any SR write in the same cycle
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: directed cycles push expectations,
// a negedge monitor pops and compares req / cp0_rdata / epc_out.
module tb_cp0_exception_unit;

  localparam logic [31:0] PRID = 32'h4255_4141;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic [4:0]  cp0_raddr;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        cp0_we;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic        exl_clr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;

  cp0_exception_unit #(.PRID_VAL(PRID), .HANDLER_PC(HPC)) dut (
    .clk(clk), .reset(reset),
    .cp0_raddr(cp0_raddr), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_we(cp0_we), .m_pc(m_pc), .m_bd(m_bd), .m_exccode(m_exccode),
    .exl_clr(exl_clr), .hw_int(hw_int), .cp0_rdata(cp0_rdata),
    .epc_out(epc_out), .req(req), .handler_pc(handler_pc)
  );

  typedef struct {
    string       name;
    logic        exp_req;
    logic [31:0] exp_rdata;
    bit          chk_epc;
    logic [31:0] exp_epc;
  } exp_t;

  exp_t exp_q[$];
  bit   strobe;
  int   checks;
  int   errors;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare DUT outputs on the falling edge whenever a cycle is presented
  always @(negedge clk) begin
    if (strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: DUT output presented with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (req !== e.exp_req) begin
          errors++;
          $display("FAIL %s req: got %b want %b", e.name, req, e.exp_req);
        end
        checks++;
        if (cp0_rdata !== e.exp_rdata) begin
          errors++;
          $display("FAIL %s rdata(%0d): got %h want %h", e.name, cp0_raddr, cp0_rdata, e.exp_rdata);
        end
        if (e.chk_epc) begin
          checks++;
          if (epc_out !== e.exp_epc) begin
            errors++;
            $display("FAIL %s epc_out: got %h want %h", e.name, epc_out, e.exp_epc);
          end
        end
        checks++;
        if (handler_pc !== HPC) begin
          errors++;
          $display("FAIL %s handler_pc: got %h want %h", e.name, handler_pc, HPC);
        end
      end
    end
  end

  task automatic idle();
    reset = 1'b0; cp0_raddr = 5'd0; cp0_waddr = 5'd0; cp0_wdata = 32'd0;
    cp0_we = 1'b0; m_pc = 32'd0; m_bd = 1'b0; m_exccode = 5'd0;
    exl_clr = 1'b0; hw_int = 6'd0;
  endtask

  // Present current inputs for one cycle with the given expectation
  task automatic cyc(input string nm, input logic [4:0] ra, input logic er,
                     input logic [31:0] erd, input bit ce, input logic [31:0] eepc);
    exp_t e;
    cp0_raddr = ra;
    e.name = nm; e.exp_req = er; e.exp_rdata = erd; e.chk_epc = ce; e.exp_epc = eepc;
    exp_q.push_back(e);
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  initial begin
    strobe = 1'b0; checks = 0; errors = 0; done = 1'b0;
    idle();
    @(posedge clk); #1;

    // T1: reset blocks req
    reset = 1'b1; m_exccode = 5'd4;
    cyc("t1_rst_a", 5'd15, 1'b0, PRID, 1'b0, 32'd0);
    cyc("t1_rst_b", 5'd12, 1'b0, 32'd0, 1'b0, 32'd0);
    idle();
    cyc("t1_sr0",    5'd12, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc("t1_cause0", 5'd13, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc("t1_epc0",   5'd14, 1'b0, 32'd0, 1'b1, 32'd0);
    cyc("t1_prid",   5'd15, 1'b0, PRID, 1'b0, 32'd0);

    // T2: exception entry, then nested exception suppressed
    m_exccode = 5'd12; m_pc = 32'h3010;
    cyc("t2_take", 5'd14, 1'b1, 32'd0, 1'b0, 32'd0);
    idle(); m_exccode = 5'd10;
    cyc("t2_nested", 5'd13, 1'b0, 32'h0000_0030, 1'b1, 32'h3010);
    idle();
    cyc("t2_sr_exl", 5'd12, 1'b0, 32'h0000_0002, 1'b0, 32'd0);
    exl_clr = 1'b1;
    cyc("t2_eret", 5'd14, 1'b0, 32'h3010, 1'b0, 32'd0);
    idle();
    cyc("t2_sr_clr", 5'd12, 1'b0, 32'd0, 1'b0, 32'd0);

    // T3: branch-delay exception
    m_bd = 1'b1; m_pc = 32'h3024; m_exccode = 5'd10;
    cyc("t3_take", 5'd13, 1'b1, 32'h0000_0030, 1'b0, 32'd0);
    idle();
    cyc("t3_cause_bd", 5'd13, 1'b0, 32'h8000_0028, 1'b1, 32'h3020);
    exl_clr = 1'b1;
    cyc("t3_eret", 5'd12, 1'b0, 32'h0000_0002, 1'b0, 32'd0);

    // T4: interrupt enable via mtc0 SR
    idle(); cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401;
    cyc("t4_mtc0_nobypass", 5'd12, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(); hw_int = 6'b000001; m_pc = 32'h3100;
    cyc("t4_int_take", 5'd12, 1'b1, 32'h0000_0401, 1'b0, 32'd0);
    idle(); hw_int = 6'b000001;
    cyc("t4_cause_int", 5'd13, 1'b0, 32'h0000_0400, 1'b1, 32'h3100);
    exl_clr = 1'b1; cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0400;
    cyc("t4_ie_off", 5'd12, 1'b0, 32'h0000_0403, 1'b0, 32'd0);
    idle(); hw_int = 6'b000001;
    cyc("t4_ie0_noreq", 5'd13, 1'b0, 32'h0000_0400, 1'b0, 32'd0);

    // T5: interrupt and exception together, mtc0 EPC ignored
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401;
    cyc("t5_ie_on", 5'd12, 1'b0, 32'h0000_0400, 1'b0, 32'd0);
    idle(); hw_int = 6'b000001; m_exccode = 5'd12; m_pc = 32'h3200;
    cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_5000;
    cyc("t5_both", 5'd14, 1'b1, 32'h3100, 1'b0, 32'd0);
    idle(); hw_int = 6'b000001;
    cyc("t5_int_wins", 5'd13, 1'b0, 32'h0000_0400, 1'b1, 32'h3200);

    // T6: eret then pending interrupt fires
    exl_clr = 1'b1;
    cyc("t6_eret", 5'd12, 1'b0, 32'h0000_0403, 1'b0, 32'd0);
    idle(); hw_int = 6'b000001; m_pc = 32'h3300;
    cyc("t6_refire", 5'd12, 1'b1, 32'h0000_0401, 1'b0, 32'd0);
    idle();
    cyc("t6_epc", 5'd14, 1'b0, 32'h3300, 1'b1, 32'h3300);

    // mtc0 SR with eret together: EXL written then cleared
    exl_clr = 1'b1; cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    cyc("sr_and_eret", 5'd12, 1'b0, 32'h0000_0403, 1'b0, 32'd0);
    idle(); cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_1237;
    cyc("sr_masked", 5'd12, 1'b0, 32'h0000_FC01, 1'b0, 32'd0);
    idle(); cp0_we = 1'b1; cp0_waddr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    cyc("mtc0_epc", 5'd14, 1'b0, 32'h0000_1234, 1'b1, 32'h1234);
    idle();
    cyc("cause_ro", 5'd13, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc("unmapped", 5'd7, 1'b0, 32'd0, 1'b0, 32'd0);

    // Reset mid-handler
    m_exccode = 5'd4; m_pc = 32'h3400;
    cyc("pre_rst_take", 5'd12, 1'b1, 32'h0000_FC01, 1'b0, 32'd0);
    idle(); reset = 1'b1; m_exccode = 5'd4; hw_int = 6'b000001;
    cyc("rst_mid", 5'd13, 1'b0, 32'h0000_0010, 1'b1, 32'h3400);
    idle();
    cyc("post_rst_sr", 5'd12, 1'b0, 32'd0, 1'b1, 32'd0);
    cyc("post_rst_cause", 5'd13, 1'b0, 32'd0, 1'b0, 32'd0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1);
    end
  end

endmodule
